fp_add_sub_pipe: RTL
====================

# fp_add_sub_pipe

Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor for the Deep-Q-Network datapath. It is the successor to the single-stage mantissa add/sub block and adds several capabilities: unpack/align, effective-operation select, normalisation, round-to-nearest-even and special-value handling. Format widths are parameters (default binary32). It accepts one operation per cycle with fixed 3-cycle latency and feeds the MAC/accumulate and weight-update units.

## Interface
- EXP_W, 8: exponent field width (≥4).
- MAN_W, 23: stored mantissa field width (≥4); hidden bit implied.
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- valid_in  in  1  a, b, op_sub are sampled this cycle.
- op_sub  in  1  0: a+b, 1: a−b.
- a  in  1+EXP_W+MAN_W  operand A {sign, exp, man}.
- b  in  1+EXP_W+MAN_W  operand B.
- valid_out  out  1  result/flags valid this cycle.
- result  out  1+EXP_W+MAN_W  rounded sum/difference.
- overflow  out  1  finite inputs, rounded result saturated to ±inf.
- invalid  out  1  result is canonical qNaN.

## Operation
- Unpack: exp==0 → operand is ±0 (denormals flushed, sign kept); exp all-ones, man==0 → ±inf; exp all-ones, man≠0 → NaN. Effective sign of B = b.sign ^ op_sub.
- Stage 1 (align): compare magnitudes {exp,man}; larger → M, smaller → m; effective subtract = sign(M) ^ sign(m). Result sign = sign of M. Shift m right by d = expM−expm into a MAN_W+4-bit field {hidden, man, G, R, S}; every bit shifted past S ORs into S. d ≥ MAN_W+3 → m field = {0…0, S=(m≠0)}.
- Stage 2 (add): MAN_W+5-bit sum {carry, field}: M+m or M−m (M ≥ m always, never negative).
- Stage 3 (normalise/round/pack): carry=1 → shift right 1 (LSB ORed into S), exp+1; else left-shift by leading-zero count, exp−lz. RNE: increment when G & (R | S | LSB). Rounding carry-out → exp+1, mantissa 0. Exponent arithmetic in EXP_W+2-bit signed.
- Overflow: final exp ≥ all-ones → ±inf, overflow=1.
- Underflow: final exp ≤ 0 → ±0 (sign kept), no flag.
- Exact zero sum: +0, except (−0)+(−0) → −0.
- Specials (override arithmetic, resolved in stage 1 and carried as tags): any NaN, or inf−inf effective subtract → {0, all-ones, 1, 0…0}, invalid=1; one inf → that inf (B's effective sign); inf+inf same sign → that inf, overflow=0.
- overflow and invalid are mutually exclusive; both 0 when valid_out=0 is irrelevant (they hold).

## Timing
- Latency 3 cycles: valid_in at edge n → valid_out high after edge n+3. Throughput 1/cycle, no backpressure, no stall.
- valid shift-register advances every cycle. Each stage's data registers load only when that stage's valid is 1, else hold. Therefore result/overflow/invalid hold their last valid values while valid_out=0.
- Reset (asynchronous, any time, incl. mid-flight): all pipeline registers clear immediately; valid_out=0, result=0, overflow=0, invalid=0. In-flight operations are discarded; the first valid_in after rstn deasserts produces valid_out 3 cycles later.
- Back-to-back and gapped valid_in streams retain order and pairing exactly.

## Test plan
- 0x3F800000 + 0x40000000 (op_sub=0) → 3 cycles later valid_out=1, result=0x40400000, flags 0.
- 0x40490FDB − 0x40490FDB → 0x00000000; 0x80000000 + 0x80000000 → 0x80000000; 0x00400000 (denormal) + 0x3F800000 → 0x3F800000.
- RNE: 0x3F800000 + 0x33800000 → 0x3F800000 (tie to even); 0x3F800000 + 0x33800001 → 0x3F800001; 0x3F800001 + 0x33800000 → 0x3F800002.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1; 0x7F800000 − 0x7F800000 → 0x7FC00000, invalid=1; 0xFF800000 + 0x3F800000 → 0xFF800000.
- Stream 8 ops back-to-back then gaps of 1–3 cycles with random a/b/op_sub → results match reference model in order; outputs hold between valid_out pulses.
- Assert rstn low with 2 ops in flight → outputs 0 same cycle, no stale valid_out after release; next op completes at +3.

Source files
------------

// File: rtl/fp_add_sub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor: align, add, normalise/round/pack.
// Denormal inputs flush to zero; special values are resolved up front and carried as tags.
module fp_add_sub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 valid_in,
  input  logic                 op_sub,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 valid_out,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 invalid
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int F    = MAN_W + 4;
  localparam int LZ_W = $clog2(F + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EXP_W+1:0] E_ONE = (EXP_W+2)'(1);

  logic [2:0] valid_q;

  logic             s1_sign_d, s1_sub_d, s1_spec_d, s1_inv_d;
  logic [EXP_W-1:0] s1_exp_d;
  logic [F-1:0]     s1_big_d, s1_small_d;
  logic [W-1:0]     s1_spec_val_d;
  logic             s1_sign_q, s1_sub_q, s1_spec_q, s1_inv_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [F-1:0]     s1_big_q, s1_small_q;
  logic [W-1:0]     s1_spec_val_q;

  logic [F:0]       s2_sum_d;
  logic             s2_sign_q, s2_sub_q, s2_spec_q, s2_inv_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [F:0]       s2_sum_q;
  logic [W-1:0]     s2_spec_val_q;

  logic [W-1:0] res_d, res_q;
  logic         ovf_d, ovf_q, inv_d, inv_q;

  logic             sign_a, sign_b, a_nan, b_nan, a_inf, b_inf, a_is_big;
  logic [W-2:0]     mag_a, mag_b, mag_big, mag_small;
  logic [F-1:0]     small_pre;
  logic [2*F-1:0]   small_ext;
  logic [31:0]      shift_d;

  always_comb begin
    sign_a    = a[W-1];
    sign_b    = b[W-1] ^ op_sub;
    a_nan     = (a[W-2:MAN_W] == EXP_ONES) && (|a[MAN_W-1:0]);
    b_nan     = (b[W-2:MAN_W] == EXP_ONES) && (|b[MAN_W-1:0]);
    a_inf     = (a[W-2:MAN_W] == EXP_ONES) && !(|a[MAN_W-1:0]);
    b_inf     = (b[W-2:MAN_W] == EXP_ONES) && !(|b[MAN_W-1:0]);
    mag_a     = (a[W-2:MAN_W] == '0) ? '0 : a[W-2:0];
    mag_b     = (b[W-2:MAN_W] == '0) ? '0 : b[W-2:0];
    a_is_big  = mag_a >= mag_b;
    mag_big   = a_is_big ? mag_a : mag_b;
    mag_small = a_is_big ? mag_b : mag_a;

    s1_sign_d = a_is_big ? sign_a : sign_b;
    s1_sub_d  = sign_a ^ sign_b;
    s1_exp_d  = mag_big[W-2:MAN_W];
    s1_big_d  = (mag_big == '0) ? '0 : {1'b1, mag_big[MAN_W-1:0], 3'b000};
    small_pre = (mag_small == '0) ? '0 : {1'b1, mag_small[MAN_W-1:0], 3'b000};
    shift_d   = 32'(mag_big[W-2:MAN_W]) - 32'(mag_small[W-2:MAN_W]);
    // Shift through a double-width field so everything falling off the end feeds sticky.
    small_ext = {small_pre, {F{1'b0}}} >> shift_d;
    if (shift_d >= 32'(MAN_W + 3))
      s1_small_d = {{(F-1){1'b0}}, |small_pre};
    else
      s1_small_d = small_ext[2*F-1:F] | {{(F-1){1'b0}}, |small_ext[F-1:0]};

    s1_spec_d     = a_nan | b_nan | a_inf | b_inf;
    s1_inv_d      = a_nan | b_nan | (a_inf & b_inf & (sign_a ^ sign_b));
    s1_spec_val_d = QNAN;
    if (!s1_inv_d && a_inf)
      s1_spec_val_d = {sign_a, EXP_ONES, {MAN_W{1'b0}}};
    else if (!s1_inv_d)
      s1_spec_val_d = {sign_b, EXP_ONES, {MAN_W{1'b0}}};
  end

  always_comb begin
    if (s1_sub_q)
      s2_sum_d = {1'b0, s1_big_q} - {1'b0, s1_small_q};
    else
      s2_sum_d = {1'b0, s1_big_q} + {1'b0, s1_small_q};
  end

  logic [LZ_W-1:0]         lz;
  logic [F-1:0]            norm;
  logic signed [EXP_W+1:0] e_base, e_norm, e_fin;
  logic [MAN_W:0]          man_r;
  logic                    rnd_inc;

  always_comb begin
    lz = '0;
    for (int i = 0; i < F; i++)
      if (s2_sum_q[i]) lz = LZ_W'(F - 1 - i);
    e_base = $signed({2'b00, s2_exp_q});
    if (s2_sum_q[F]) begin
      norm   = s2_sum_q[F:1] | {{(F-1){1'b0}}, s2_sum_q[0]};
      e_norm = e_base + E_ONE;
    end else begin
      norm   = s2_sum_q[F-1:0] << lz;
      e_norm = e_base - $signed((EXP_W+2)'(lz));
    end
    // Round to nearest even on {G, R, S} with the kept LSB breaking ties.
    rnd_inc = norm[2] & (norm[1] | norm[0] | norm[3]);
    man_r   = {1'b0, norm[F-2:3]} + (MAN_W+1)'(rnd_inc);
    e_fin   = man_r[MAN_W] ? e_norm + E_ONE : e_norm;

    res_d = {s2_sign_q, e_fin[EXP_W-1:0], man_r[MAN_W-1:0]};
    ovf_d = 1'b0;
    inv_d = 1'b0;
    if (s2_spec_q) begin
      res_d = s2_spec_val_q;
      inv_d = s2_inv_q;
    end else if (s2_sum_q == '0) begin
      res_d = {s2_sub_q ? 1'b0 : s2_sign_q, {(W-1){1'b0}}};
    end else if (!e_fin[EXP_W+1] && (e_fin[EXP_W:0] >= {1'b0, EXP_ONES})) begin
      res_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else if (e_fin[EXP_W+1] || (e_fin == '0)) begin
      res_d = {s2_sign_q, {(W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q       <= '0;
      s1_sign_q     <= 1'b0;
      s1_sub_q      <= 1'b0;
      s1_spec_q     <= 1'b0;
      s1_inv_q      <= 1'b0;
      s1_exp_q      <= '0;
      s1_big_q      <= '0;
      s1_small_q    <= '0;
      s1_spec_val_q <= '0;
      s2_sign_q     <= 1'b0;
      s2_sub_q      <= 1'b0;
      s2_spec_q     <= 1'b0;
      s2_inv_q      <= 1'b0;
      s2_exp_q      <= '0;
      s2_sum_q      <= '0;
      s2_spec_val_q <= '0;
      res_q         <= '0;
      ovf_q         <= 1'b0;
      inv_q         <= 1'b0;
    end else begin
      valid_q <= {valid_q[1:0], valid_in};
      if (valid_in) begin
        s1_sign_q     <= s1_sign_d;
        s1_sub_q      <= s1_sub_d;
        s1_spec_q     <= s1_spec_d;
        s1_inv_q      <= s1_inv_d;
        s1_exp_q      <= s1_exp_d;
        s1_big_q      <= s1_big_d;
        s1_small_q    <= s1_small_d;
        s1_spec_val_q <= s1_spec_val_d;
      end
      if (valid_q[0]) begin
        s2_sign_q     <= s1_sign_q;
        s2_sub_q      <= s1_sub_q;
        s2_spec_q     <= s1_spec_q;
        s2_inv_q      <= s1_inv_q;
        s2_exp_q      <= s1_exp_q;
        s2_sum_q      <= s2_sum_d;
        s2_spec_val_q <= s1_spec_val_q;
      end
      if (valid_q[1]) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        inv_q <= inv_d;
      end
    end
  end

  assign valid_out = valid_q[2];
  assign result    = res_q;
  assign overflow  = ovf_q;
  assign invalid   = inv_q;
endmodule
